// File: rtl/q1_truth_unit.sv
// q1_truth_unit: registered 4-input Boolean lookup producing f and g.
// idx = {a,b,c,d} (a is the MSB). f = F_TRUTH[idx] and g = G_TRUTH[idx],
// both registered with one cycle of latency. The default tables make
// f = "idx is prime" and g = "idx divisible by 3".
// Optional build macro Q1_INPUT_SYNC_EN: each input first passes through a
// 2-flop synchronizer, which makes the total latency 3 cycles.
module q1_truth_unit #(
    parameter logic [15:0] F_TRUTH = 16'h28AC,
    parameter logic [15:0] G_TRUTH = 16'h9249
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f,
    output logic g
);

    logic [3:0] idx;

`ifdef Q1_INPUT_SYNC_EN
    logic [3:0] sync1;
    logic [3:0] sync2;

    // Two-stage synchronizer on the raw inputs. It clears to idx 0, so the
    // outputs show the idx-0 entry while the pipeline refills after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {a, b, c, d};
            sync2 <= sync1;
        end
    end

    assign idx = sync2;
`else
    assign idx = {a, b, c, d};
`endif

    // Table lookup straight into the output flops, so f and g have no
    // combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            f <= 1'b0;
            g <= 1'b0;
        end else begin
            f <= F_TRUTH[idx];
            g <= G_TRUTH[idx];
        end
    end

endmodule

// File: tb/tb_q1_truth_unit.sv
// Scoreboard bench for q1_truth_unit. The default instance is checked
// against primality / divisibility-by-3 rules. A second instance, with the
// tables overridden to one-hot entries, is checked against idx==0 / idx==15.
// The driver pushes one expected entry per edge, and the monitor pops and
// compares that entry just after the edge.
module tb_q1_truth_unit;

    logic clk = 1'b0;
    logic rst;
    logic a, b, c, d;
    logic f, g, f2, g2;

    typedef struct packed {
        logic f;
        logic g;
        logic f2;
        logic g2;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    always #5 clk = ~clk;

    q1_truth_unit dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .f(f), .g(g)
    );

    q1_truth_unit #(.F_TRUTH(16'h0001), .G_TRUTH(16'h8000)) dut_ovr (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .f(f2), .g(g2)
    );

    function automatic logic is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++)
            if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t model(input int n);
        exp_t e;
        e.f  = is_prime(n);
        e.g  = (n % 3 == 0);
        e.f2 = (n == 0);
        e.g2 = (n == 15);
        return e;
    endfunction

`ifdef Q1_INPUT_SYNC_EN
    int s1 = 0;
    int s2 = 0;
`endif

    // One cycle of stimulus: drive the inputs on the falling edge and push
    // the values the outputs must show after the next rising edge.
    task automatic step(input bit r, input int n);
        exp_t e;
        @(negedge clk);
        rst = r;
        {a, b, c, d} = 4'(n);
`ifdef Q1_INPUT_SYNC_EN
        e  = r ? exp_t'('0) : model(s2);
        s2 = r ? 0 : s1;
        s1 = r ? 0 : n;
`else
        e = r ? exp_t'('0) : model(n);
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the outputs with the oldest
    // expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({f, g} !== {e.f, e.g}) begin
                    n_bad++;
                    $display("FAIL default_fg: got f=%b g=%b expected f=%b g=%b (t=%0t)",
                             f, g, e.f, e.g, $time);
                end
                n_cmp++;
                if ({f2, g2} !== {e.f2, e.g2}) begin
                    n_bad++;
                    $display("FAIL override_fg: got f=%b g=%b expected f=%b g=%b (t=%0t)",
                             f2, g2, e.f2, e.g2, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        {a, b, c, d} = 4'b1111;
        // Hold reset for two edges with all inputs high, then release.
        step(1, 15);
        step(1, 15);
        step(0, 15);
        // Sweep every idx, one per cycle.
        for (int i = 0; i < 16; i++) step(0, i);
        // Back-to-back indices.
        step(0, 5);
        step(0, 6);
        // Reset in mid-stream while idx stays at 7.
        step(0, 7);
        step(1, 7);
        step(0, 7);
        step(0, 7);
        // Step from idx 0 to idx 11 and hold.
        step(0, 0);
        step(0, 0);
        step(0, 0);
        for (int i = 0; i < 4; i++) step(0, 11);
        // Random indices with occasional reset.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 15) == 0), int'($urandom_range(0, 15)));
        // Let the last expected entries drain, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/q1_truth_unit.md
Name: q1_truth_unit

Overview:
- Registered 4-input Boolean function unit producing two outputs, f and g, from single-bit inputs a, b, c, d.
- The inputs form a 4-bit index idx = {a,b,c,d}, with a as the MSB.
- Each output is the bit of a 16-entry truth-table parameter selected by idx, registered on the clock.
- Used as a small decode/classification leaf cell in control logic. Defaults make f = "idx is prime" and g = "idx divisible by 3".

Parameters:
- F_TRUTH, 16'h28AC: truth table for f. Bit n is the f value when idx == n. Default sets bits 2, 3, 5, 7, 11, 13 (primes).
- G_TRUTH, 16'h9249: truth table for g. Bit n is the g value when idx == n. Default sets bits 0, 3, 6, 9, 12, 15 (multiples of 3).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a    input  1  idx bit 3 (MSB)
- b    input  1  idx bit 2
- c    input  1  idx bit 1
- d    input  1  idx bit 0 (LSB)
- f    output 1  registered F_TRUTH[idx]
- g    output 1  registered G_TRUTH[idx]

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst is sampled only on the rising edge of clk.
- Reset: on any rising edge with rst=1, f <= 0 and g <= 0, regardless of the inputs.
- Normal operation: on each rising edge with rst=0:
  - idx = {a,b,c,d}, sampled at that edge
  - f <= F_TRUTH[idx]
  - g <= G_TRUTH[idx]
- Latency: 1 cycle. An input change applied before edge N appears on f/g immediately after edge N.
- Throughput: one new index per cycle. No handshake; inputs are assumed stable around the edge.
- f and g are driven directly from flops, with no combinational path from a..d to f/g. Outputs hold their value between edges.
- Reset mid-operation: the reset edge forces 0 on both outputs. The first non-reset edge afterwards loads the table value for the current idx; no history is retained.
- Reset is released on the edge where rst=0 is sampled; outputs update normally on that same edge.
- Inputs are treated as 2-state. X/Z on any input is outside the defined behaviour and needs no specific handling.
- Default-table full map (idx: f g):
  - 0: 0 1
  - 1: 0 0
  - 2: 1 0
  - 3: 1 1
  - 4: 0 0
  - 5: 1 0
  - 6: 0 1
  - 7: 1 0
  - 8: 0 0
  - 9: 0 1
  - 10: 0 0
  - 11: 1 0
  - 12: 0 1
  - 13: 1 0
  - 14: 0 0
  - 15: 0 1

Optional Feature:
- Macro Q1_INPUT_SYNC_EN.
- Defined:
  - a, b, c, d each pass through a 2-flop synchronizer before table lookup.
  - Total latency becomes 3 cycles.
  - Synchronizer flops reset to 0 on rst. While the pipeline refills after reset, outputs reflect idx 0 (f=0, g=1 with default tables).
- Undefined: no synchronizer; 1-cycle latency exactly as specified above.

Test Plan:
- Hold rst=1 for 2 edges with a..d=1111 -> f=0, g=0 after each edge. Deassert rst -> after the next edge f=0, g=1 (idx 15).
- Sweep idx 0..15, one per cycle, with rst=0 -> each output one cycle later matches the default map. Spot checks: idx 3 -> f=1, g=1; idx 13 -> f=1, g=0; idx 0 -> f=0, g=1.
- Apply idx 5 then idx 6 on consecutive cycles -> f/g sequence 1/0 then 0/1 with no idle cycle between (back-to-back throughput).
- Drive idx 7, then assert rst for one edge while idx stays 7 -> f/g go 1/0, then 0/0, then 1/0 on the first edge after rst drops.
- Override parameters F_TRUTH=16'h0001, G_TRUTH=16'h8000, sweep 0..15 -> f=1 only for idx 0, g=1 only for idx 15.
- With Q1_INPUT_SYNC_EN defined, step idx from 0 to 11 -> f rises to 1 exactly 3 edges after the change; g falls 1 -> 0 on the same edge.
